muldiv_sequencer: RTL and testbench

//   Multi-cycle controller/datapath for RV64M MUL/DIV/REM (+W forms), sharing one shift-add/restoring-subtract engine.

---
 rtl/muldiv_sequencer.sv | 265 ++++++++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - multi-cycle RV64M MUL/DIV/REM sequencer sharing one shift engine
//
// Purpose:
//   One shift-add / restoring-subtract engine serves MUL, DIV, DIVU, REM, REMU
//   and their W forms. Divide-by-zero, signed overflow and illegal opcodes
//   finish in one cycle. Everything else iterates one bit per cycle: 64
//   iterations for full-width ops and 32 for W forms.
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   reset      in   synchronous, active-high
//   flush      in   abort any op in flight; result is left untouched
//   in_valid   in   request present
//   in_ready   out  engine idle and able to accept
//   op         in   0 MUL,1 DIV,2 DIVU,3 REM,4 REMU,5 MULW,6 DIVW,7 DIVUW,8 REMW,9 REMUW
//   src1       in   multiplicand / dividend
//   src2       in   multiplier / divisor
//   out_valid  out  result held valid until out_ready
//   out_ready  in   consumer takes result
//   result     out  final value, stable while out_valid

module muldiv_sequencer #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int HALF = XLEN / 2;
  localparam int CW   = $clog2(XLEN);

  localparam logic [CW-1:0] CNT_FULL = CW'(XLEN - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

  localparam logic [3:0] OP_MUL   = 4'd0;
  localparam logic [3:0] OP_DIV   = 4'd1;
  localparam logic [3:0] OP_DIVU  = 4'd2;
  localparam logic [3:0] OP_REM   = 4'd3;
  localparam logic [3:0] OP_REMU  = 4'd4;
  localparam logic [3:0] OP_MULW  = 4'd5;
  localparam logic [3:0] OP_DIVW  = 4'd6;
  localparam logic [3:0] OP_DIVUW = 4'd7;
  localparam logic [3:0] OP_REMW  = 4'd8;
  localparam logic [3:0] OP_REMUW = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  // Engine registers are shared between the two algorithms.
  //   MUL: opa = shifting multiplicand, opb = shifting multiplier, acc = product
  //   DIV: opa = divisor magnitude, opb = dividend shifting into quotient, acc = remainder
  logic [XLEN-1:0] opa, opb, acc;
  logic [CW-1:0]   counter;
  logic            mul_q, rem_q, w_q, neg_quot_q, neg_rem_q;

  // Narrow results are always sign-extended from bit 31, unsigned forms included.
  function automatic logic [XLEN-1:0] wfix(input logic w, input logic [XLEN-1:0] x);
    return w ? {{HALF{x[HALF-1]}}, x[HALF-1:0]} : x;
  endfunction

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic in_legal, in_w, in_mul, in_rem, in_signed, in_zext;

  always_comb begin
    in_legal  = 1'b1;
    in_w      = 1'b0;
    in_mul    = 1'b0;
    in_rem    = 1'b0;
    in_signed = 1'b0;
    in_zext   = 1'b0;
    case (op)
      OP_MUL:   in_mul = 1'b1;
      OP_DIV:   in_signed = 1'b1;
      OP_DIVU:  ;
      OP_REM:   begin in_rem = 1'b1; in_signed = 1'b1; end
      OP_REMU:  in_rem = 1'b1;
      OP_MULW:  begin in_w = 1'b1; in_mul = 1'b1; end
      OP_DIVW:  begin in_w = 1'b1; in_signed = 1'b1; end
      OP_DIVUW: begin in_w = 1'b1; in_zext = 1'b1; end
      OP_REMW:  begin in_w = 1'b1; in_rem = 1'b1; in_signed = 1'b1; end
      OP_REMUW: begin in_w = 1'b1; in_rem = 1'b1; in_zext = 1'b1; end
      default:  in_legal = 1'b0;
    endcase
  end

  // Operands at the operating width: W forms keep only the low half and extend
  // it according to signedness (MULW extension does not affect the low product).
  logic [XLEN-1:0] ext1, ext2, min_val, mag1, mag2;
  logic            div_zero, div_ovf, fast;
  logic [XLEN-1:0] fast_result;

  always_comb begin
    if (in_zext) begin
      ext1 = {{HALF{1'b0}}, src1[HALF-1:0]};
      ext2 = {{HALF{1'b0}}, src2[HALF-1:0]};
    end else if (in_w) begin
      ext1 = {{HALF{src1[HALF-1]}}, src1[HALF-1:0]};
      ext2 = {{HALF{src2[HALF-1]}}, src2[HALF-1:0]};
    end else begin
      ext1 = src1;
      ext2 = src2;
    end

    // Most negative value at the operating width, already sign-extended.
    min_val = in_w ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}}
                   : {1'b1, {(XLEN-1){1'b0}}};

    div_zero = (ext2 == '0);
    div_ovf  = in_signed && (ext1 == min_val) && (ext2 == '1);
    fast     = !in_legal || (!in_mul && (div_zero || div_ovf));

    if (!in_legal)
      fast_result = '0;
    else if (div_zero)
      fast_result = in_rem ? wfix(in_w, ext1) : '1;
    else if (in_rem)
      fast_result = '0;
    else
      fast_result = min_val;

    // Signed division works on magnitudes; -MIN wraps to MIN, which is the
    // correct unsigned magnitude.
    mag1 = (in_signed && ext1[XLEN-1]) ? (~ext1 + 1'b1) : ext1;
    mag2 = (in_signed && ext2[XLEN-1]) ? (~ext2 + 1'b1) : ext2;
  end

  // ---------------------------------------------------------------------------
  // One iteration of the shared engine
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] opa_n, opb_n, acc_n, final_result;
  logic [XLEN:0]   rem_shift, rem_trial;

  always_comb begin
    // The remainder can reach 2*divisor-1 after the shift, so one extra bit
    // keeps the compare correct for divisors above 2^(XLEN-1).
    rem_shift = {acc, opb[XLEN-1]};
    rem_trial = rem_shift - {1'b0, opa};

    if (mul_q) begin
      opa_n = opa << 1;
      opb_n = opb >> 1;
      acc_n = opb[0] ? (acc + opa) : acc;
    end else begin
      opa_n = opa;
      if (!rem_trial[XLEN]) begin
        acc_n = rem_trial[XLEN-1:0];
        opb_n = {opb[XLEN-2:0], 1'b1};
      end else begin
        acc_n = rem_shift[XLEN-1:0];
        opb_n = {opb[XLEN-2:0], 1'b0};
      end
    end

    if (mul_q)
      final_result = wfix(w_q, acc_n);
    else if (rem_q)
      final_result = wfix(w_q, neg_rem_q ? (~acc_n + 1'b1) : acc_n);
    else
      final_result = wfix(w_q, neg_quot_q ? (~opb_n + 1'b1) : opb_n);
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          state_next = fast ? DONE : BUSY;
      end
      BUSY: begin
        if (counter == '0)
          state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (flush)
      state_next = IDLE;
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      opa        <= '0;
      opb        <= '0;
      acc        <= '0;
      counter    <= '0;
      result     <= '0;
      mul_q      <= 1'b0;
      rem_q      <= 1'b0;
      w_q        <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else if (!flush) begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mul_q      <= in_mul;
            rem_q      <= in_rem;
            w_q        <= in_w;
            neg_quot_q <= in_signed && (ext1[XLEN-1] ^ ext2[XLEN-1]);
            neg_rem_q  <= in_signed && ext1[XLEN-1];
            counter    <= in_w ? CNT_HALF : CNT_FULL;
            acc        <= '0;
            if (fast) begin
              result <= fast_result;
            end else if (in_mul) begin
              opa <= ext1;
              opb <= ext2;
            end else begin
              opa <= mag2;
              // W dividends start in the upper half so that 32 shifts
              // consume exactly their 32 bits.
              opb <= in_w ? (mag1 << HALF) : mag1;
            end
          end
        end
        BUSY: begin
          opa     <= opa_n;
          opb     <= opb_n;
          acc     <= acc_n;
          counter <= counter - 1'b1;
          if (counter == '0)
            result <= final_result;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - self-checking bench for muldiv_sequencer

module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  op;
  logic [63:0] src1, src2, result;

  int checks = 0;
  int errors = 0;

  logic [63:0] sb[$];

  typedef struct {
    logic [3:0]  op;
    logic [63:0] s1;
    logic [63:0] s2;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  muldiv_sequencer #(.XLEN(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src1      (src1),
    .src2      (src2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input string name, input logic [3:0] o, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input int lat);
    int          cycles;
    logic [63:0] want;
    @(negedge clk);
    chk({name, " in_ready"}, {63'd0, in_ready}, 64'd1);
    op = o; src1 = a; src2 = b; in_valid = 1'b1;
    sb.push_back(exp);
    @(posedge clk);
    #1 in_valid = 1'b0;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!out_valid && cycles < 200);
    want = sb.pop_front();
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no out_valid after %0d cycles, required %0d", name, cycles, lat);
      return;
    end
    chk({name, " latency"}, 64'(cycles), 64'(lat));
    chk({name, " result"}, result, want);
    // Result must hold while the consumer stalls.
    repeat (2) @(negedge clk);
    chk({name, " held valid"}, {63'd0, out_valid}, 64'd1);
    chk({name, " held result"}, result, want);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk({name, " back to idle"}, {62'd0, in_ready, out_valid}, 64'b10);
  endtask

  initial begin
    int          cycles;
    logic        seen;

    vecs.push_back('{4'd0, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 65});
    vecs.push_back('{4'd1, -64'sd20, 64'd3, -64'sd6, 65});
    vecs.push_back('{4'd3, -64'sd20, 64'd3, -64'sd2, 65});
    vecs.push_back('{4'd1, 64'd20, -64'sd3, -64'sd6, 65});
    vecs.push_back('{4'd3, 64'd20, -64'sd3, 64'd2, 65});
    vecs.push_back('{4'd2, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1});
    vecs.push_back('{4'd4, 64'd5, 64'd0, 64'd5, 1});
    vecs.push_back('{4'd1, 64'h8000_0000_0000_0000, -64'sd1, 64'h8000_0000_0000_0000, 1});
    vecs.push_back('{4'd3, 64'h8000_0000_0000_0000, -64'sd1, 64'd0, 1});
    vecs.push_back('{4'd7, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33});
    vecs.push_back('{4'd5, 64'h1_0000, 64'h1_0000, 64'd0, 33});
    vecs.push_back('{4'd5, 64'h4000_0000, 64'd2, 64'hFFFF_FFFF_8000_0000, 33});
    vecs.push_back('{4'd2, 64'd100, 64'd7, 64'd14, 65});
    vecs.push_back('{4'd4, 64'd100, 64'd7, 64'd2, 65});
    vecs.push_back('{4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'd1, 65});
    vecs.push_back('{4'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFE, 65});
    vecs.push_back('{4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 65});
    vecs.push_back('{4'd6, 64'h1234_5678_FFFF_FFEC, 64'd3, -64'sd6, 33});
    vecs.push_back('{4'd8, 64'h1234_5678_FFFF_FFEC, 64'd3, -64'sd2, 33});
    vecs.push_back('{4'd6, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1});
    vecs.push_back('{4'd9, 64'h8000_0000, 64'd0, 64'hFFFF_FFFF_8000_0000, 1});
    vecs.push_back('{4'd10, 64'd9, 64'd9, 64'd0, 1});

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 4'd0; src1 = '0; src2 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset result", result, 64'd0);

    for (int i = 0; i < vecs.size(); i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].s1, vecs[i].s2, vecs[i].exp, vecs[i].lat);

    // Flush in the tenth BUSY cycle: op abandoned, no output ever.
    @(negedge clk);
    op = 4'd1; src1 = 64'd1000; src2 = 64'd7; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush idle", {62'd0, in_ready, out_valid}, 64'b10);
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("flush no output", {63'd0, seen}, 64'd0);
    run_op("after flush", 4'd1, 64'd1000, -64'sd7, -64'sd142, 65);

    // Flush together with a request in IDLE: nothing accepted.
    @(negedge clk);
    op = 4'd0; src1 = 64'd3; src2 = 64'd4; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 begin in_valid = 1'b0; flush = 1'b0; end
    @(negedge clk);
    chk("flush idle no accept", {62'd0, in_ready, out_valid}, 64'b10);

    // Reset in the middle of a multiply.
    @(negedge clk);
    op = 4'd0; src1 = 64'd3; src2 = 64'd5; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("busy in_ready", {63'd0, in_ready}, 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("midreset ready/valid", {62'd0, in_ready, out_valid}, 64'b10);
    chk("midreset result", result, 64'd0);
    run_op("after reset", 4'd0, 64'd3, 64'd5, 64'd15, 65);

    chk("scoreboard empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: bench did not finish");
    $fatal(1);
  end

endmodule
